darkriscv_ifetch: RTL and testbench



---
 rtl/darkriscv_ifetch_pkg.sv | 30 +++
 rtl/darkriscv_fifo.sv | 62 ++++++
 rtl/darkriscv_ifetch.sv | 131 +++++++++++++
 tb/tb_darkriscv_ifetch.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/darkriscv_ifetch_pkg.sv
// ============================================================================
// darkriscv_ifetch_pkg
// Shared types and constants for the darkriscv instruction fetch unit.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package darkriscv_ifetch_pkg;

  localparam logic [31:0] c_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_REQ   = 2'd1,
    IF_DRAIN = 2'd2
  } if_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/darkriscv_fifo.sv
// ============================================================================
// darkriscv_fifo
// Synchronous FIFO with flush, registered storage and occupancy count.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module darkriscv_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RES,
  input  logic                       FLUSH,
  input  logic                       PUSH,
  input  logic [WIDTH-1:0]           PUSH_DATA,
  input  logic                       POP,
  output logic [WIDTH-1:0]           HEAD,
  output logic                       FULL,
  output logic                       EMPTY,
  output logic [$clog2(DEPTH):0]     COUNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign FULL   = (r_count == CW'(DEPTH));
  assign EMPTY  = (r_count == '0);
  assign COUNT  = r_count;
  assign HEAD   = r_mem[r_rd];

  // Push while full is accepted only when a pop frees the slot this cycle.
  assign w_push = PUSH && (!FULL || POP);
  assign w_pop  = POP && !EMPTY;

  always_ff @(posedge CLK) begin
    if (RES || FLUSH) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push && !RES && !FLUSH) r_mem[r_wr] <= PUSH_DATA;
  end

endmodule

`default_nettype wire

// File: rtl/darkriscv_ifetch.sv
// ============================================================================
// darkriscv_ifetch
// Instruction fetch unit: sequential word fetch, prefetch FIFO, redirect.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module darkriscv_ifetch
  import darkriscv_ifetch_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_ADDR = c_RESET_PC
) (
  input  logic        CLK,
  input  logic        RES,
  output logic        MEM_REQ,
  output logic [31:0] MEM_ADDR,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_RDATA,
  output logic        INSTR_VALID,
  output logic [31:0] INSTR,
  output logic [31:0] INSTR_PC,
  input  logic        INSTR_READY,
  input  logic        REDIR,
  input  logic [31:0] REDIR_PC
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  if_state_t   r_state;
  if_state_t   w_state_nxt;
  logic [31:0] r_fetch_pc;
  logic [31:0] w_fetch_pc_nxt;
  logic [31:0] r_target;
  logic [31:0] w_target_nxt;
  logic [31:0] w_redir_pc;

  if_entry_t   w_push_entry;
  if_entry_t   w_head;
  logic        w_full;
  logic        w_empty;
  logic [CW-1:0] w_count;
  logic [CW:0]   w_count_nxt;
  logic        w_push;
  logic        w_pop;
  logic        w_has_room;

  assign w_redir_pc   = word_align(REDIR_PC);
  assign w_push_entry = '{pc: r_fetch_pc, instr: MEM_RDATA};

  // A redirect squashes both the same-cycle ack and the same-cycle pop.
  assign w_push = (r_state == IF_REQ) && MEM_ACK && !REDIR && (!w_full || w_pop);
  assign w_pop  = !w_empty && INSTR_READY && !REDIR;

  assign w_count_nxt = REDIR ? '0
                     : ({1'b0, w_count} + (CW+1)'(w_push) - (CW+1)'(w_pop));
  assign w_has_room  = (w_count_nxt < (CW+1)'(FIFO_DEPTH));

  darkriscv_fifo #(
    .WIDTH (64),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RES       (RES),
    .FLUSH     (REDIR),
    .PUSH      (w_push),
    .PUSH_DATA (w_push_entry),
    .POP       (w_pop),
    .HEAD      (w_head),
    .FULL      (w_full),
    .EMPTY     (w_empty),
    .COUNT     (w_count)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_target_nxt   = r_target;
    if (REDIR) begin
      // An un-acked request must still complete on its old address.
      if ((r_state != IF_IDLE) && !MEM_ACK) begin
        w_state_nxt  = IF_DRAIN;
        w_target_nxt = w_redir_pc;
      end else begin
        w_state_nxt    = IF_REQ;
        w_fetch_pc_nxt = w_redir_pc;
      end
    end else begin
      case (r_state)
        IF_IDLE: begin
          if (w_has_room) w_state_nxt = IF_REQ;
        end
        IF_REQ: begin
          if (MEM_ACK) begin
            w_fetch_pc_nxt = r_fetch_pc + 32'd4;
            w_state_nxt    = w_has_room ? IF_REQ : IF_IDLE;
          end
        end
        IF_DRAIN: begin
          if (MEM_ACK) begin
            w_fetch_pc_nxt = r_target;
            w_state_nxt    = IF_REQ;
          end
        end
        default: w_state_nxt = IF_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      r_state    <= IF_IDLE;
      r_fetch_pc <= word_align(RESET_ADDR);
      r_target   <= word_align(RESET_ADDR);
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_target   <= w_target_nxt;
    end
  end

  assign MEM_REQ     = (r_state != IF_IDLE);
  assign MEM_ADDR    = r_fetch_pc;
  assign INSTR_VALID = !w_empty;
  assign INSTR       = w_empty ? 32'h0 : w_head.instr;
  assign INSTR_PC    = w_empty ? 32'h0 : w_head.pc;

endmodule

`default_nettype wire

// File: tb/tb_darkriscv_ifetch.sv
// ============================================================================
// tb_darkriscv_ifetch
// Self-checking bench: transaction-level model of the fetch stream.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_darkriscv_ifetch;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RES = 1'b1;
  logic        MEM_REQ;
  logic [31:0] MEM_ADDR;
  logic        MEM_ACK = 1'b0;
  logic [31:0] MEM_RDATA = 32'h0;
  logic        INSTR_VALID;
  logic [31:0] INSTR;
  logic [31:0] INSTR_PC;
  logic        INSTR_READY = 1'b0;
  logic        REDIR = 1'b0;
  logic [31:0] REDIR_PC = 32'h0;

  darkriscv_ifetch #(
    .FIFO_DEPTH (DEPTH),
    .RESET_ADDR (32'h0)
  ) dut (
    .CLK         (CLK),
    .RES         (RES),
    .MEM_REQ     (MEM_REQ),
    .MEM_ADDR    (MEM_ADDR),
    .MEM_ACK     (MEM_ACK),
    .MEM_RDATA   (MEM_RDATA),
    .INSTR_VALID (INSTR_VALID),
    .INSTR       (INSTR),
    .INSTR_PC    (INSTR_PC),
    .INSTR_READY (INSTR_READY),
    .REDIR       (REDIR),
    .REDIR_PC    (REDIR_PC)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Model: words the core should see, in order, plus the next live fetch PC.
  logic [31:0] q[$];
  logic [31:0] seen[$];
  logic [31:0] mpc;
  logic        dead;
  logic        hold;
  logic [31:0] hold_addr;
  logic        pend;
  int          cnt;
  int          lat_min;
  int          lat_max;
  logic        last_ack;
  logic        found;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16] ^ ~a[15:0]};
  endfunction

  function automatic logic [31:0] seen_at(input int i);
    return (seen.size() > i) ? seen[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic rdy, input logic rd, input logic [31:0] rp);
    logic pop;
    @(negedge CLK);
    chk("valid", INSTR_VALID, q.size() != 0);
    if (q.size() != 0) begin
      chk("instr_pc", INSTR_PC, q[0]);
      chk("instr", INSTR, memf(q[0]));
    end else begin
      chk("instr_pc_zero", INSTR_PC, 32'h0);
      chk("instr_zero", INSTR, 32'h0);
    end
    chk("mem_req", MEM_REQ, q.size() < DEPTH);
    if (MEM_REQ) begin
      chk("addr_align", MEM_ADDR[1:0], 2'b00);
      if (!dead) chk("mem_addr", MEM_ADDR, mpc);
    end
    if (hold) begin
      chk("req_hold", MEM_REQ, 1'b1);
      chk("addr_hold", MEM_ADDR, hold_addr);
    end
    if (MEM_REQ) begin
      if (!pend) begin
        pend = 1'b1;
        cnt  = $urandom_range(lat_max, lat_min);
      end
      if (cnt == 0) begin
        MEM_ACK = 1'b1;
        pend    = 1'b0;
      end else begin
        cnt--;
        MEM_ACK = 1'b0;
      end
    end else begin
      MEM_ACK = 1'b0;
      pend    = 1'b0;
    end
    MEM_RDATA   = MEM_ACK ? memf(MEM_ADDR) : $urandom;
    INSTR_READY = rdy;
    REDIR       = rd;
    REDIR_PC    = rp;
    pop = (q.size() != 0) && rdy && !rd;
    if (pop) seen.push_back(INSTR_PC);
    hold      = MEM_REQ && !MEM_ACK;
    hold_addr = MEM_ADDR;
    last_ack  = MEM_REQ && MEM_ACK;
    if (rd) begin
      q.delete();
      mpc  = rp & ~32'h3;
      dead = MEM_REQ && !MEM_ACK;
    end else begin
      if (pop) void'(q.pop_front());
      if (MEM_REQ && MEM_ACK) begin
        if (dead) dead = 1'b0;
        else begin
          q.push_back(mpc);
          mpc = mpc + 32'd4;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RES = 1'b1; MEM_ACK = 1'b0; REDIR = 1'b0; INSTR_READY = 1'b0;
    @(posedge CLK); #1;
    chk("rst_mem_req", MEM_REQ, 1'b0);
    chk("rst_mem_addr", MEM_ADDR, 32'h0);
    chk("rst_valid", INSTR_VALID, 1'b0);
    chk("rst_instr", INSTR, 32'h0);
    chk("rst_instr_pc", INSTR_PC, 32'h0);
    @(negedge CLK);
    RES = 1'b0;
    q.delete(); seen.delete();
    mpc = 32'h0; dead = 1'b0; hold = 1'b0; pend = 1'b0; cnt = 0; last_ack = 1'b0;
  endtask

  task automatic wait_mid_request(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (MEM_REQ && pend && cnt >= 1) begin
        ok = 1'b1;
        break;
      end
      step(1'b1, 1'b0, 32'h0);
    end
  endtask

  initial begin
    lat_min = 0; lat_max = 0;

    // Zero-wait memory, core always ready: one instruction per cycle.
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0);
    chk("t1_pc0", seen_at(0), 32'h0);
    chk("t1_pc1", seen_at(1), 32'h4);
    chk("t1_pc2", seen_at(2), 32'h8);
    chk("t1_rate", seen.size(), 32'd7);

    // Core stalls: buffer fills to depth, then drains in order.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0);
    chk("t2_req_low", MEM_REQ, 1'b0);
    chk("t2_head_pc", INSTR_PC, 32'h0);
    chk("t2_model_fill", q.size(), 32'd4);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);
    chk("t2_d0", seen_at(0), 32'h0);
    chk("t2_d1", seen_at(1), 32'h4);
    chk("t2_d2", seen_at(2), 32'h8);
    chk("t2_d3", seen_at(3), 32'hC);
    chk("t2_d4", seen_at(4), 32'h10);

    // Redirect while a slow request waits: drain, then fetch target.
    do_reset();
    lat_min = 3; lat_max = 3;
    wait_mid_request(30, found);
    chk("t3_found_wait", found, 1'b1);
    step(1'b1, 1'b1, 32'h100);
    seen.delete();
    for (int i = 0; i < 10; i++) begin
      if (last_ack) break;
      step(1'b1, 1'b0, 32'h0);
    end
    chk("t3_drain_ack", last_ack, 1'b1);
    @(posedge CLK); #1;
    chk("t3_new_addr", MEM_ADDR, 32'h100);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 32'h0);
    chk("t3_first_pc", seen_at(0), 32'h100);

    // Redirect coinciding with ack and pop, misaligned target.
    do_reset();
    lat_min = 0; lat_max = 0;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);
    chk("t4_pre_valid", INSTR_VALID, 1'b1);
    step(1'b1, 1'b1, 32'h203);
    chk("t4_ack_same", last_ack, 1'b1);
    @(posedge CLK); #1;
    chk("t4_flushed", INSTR_VALID, 1'b0);
    chk("t4_addr", MEM_ADDR, 32'h200);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);

    // Fetch PC wraps at the top of the address space.
    do_reset();
    step(1'b1, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0);
    chk("t5_w0", seen_at(0), 32'hFFFF_FFF8);
    chk("t5_w1", seen_at(1), 32'hFFFF_FFFC);
    chk("t5_w2", seen_at(2), 32'h0000_0000);

    // Random traffic: latency, stalls and redirects.
    do_reset();
    lat_min = 0; lat_max = 3;
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0, $urandom);

    // Reset while draining: restart cleanly from the reset address.
    do_reset();
    lat_min = 5; lat_max = 5;
    wait_mid_request(30, found);
    chk("t6_found_wait", found, 1'b1);
    step(1'b1, 1'b1, 32'h300);
    do_reset();
    lat_min = 0; lat_max = 0;
    step(1'b1, 1'b0, 32'h0);
    chk("t6_req", MEM_REQ, 1'b1);
    chk("t6_addr", MEM_ADDR, 32'h0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);
    chk("t6_pc0", seen_at(0), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
